ball_detect_ctrl: RTL and testbench
===================================

Name: ball_detect_ctrl

Overview:
- Frame-sequencing and configuration controller for the red-ball detector datapath.
- Generates the ball RAM freeze control. A single-shot capture writes exactly one complete frame, then holds it.
- Owns the four Cr/Cb threshold registers, edited by pushbutton steps. Edits reach the detector only at a frame start, so every frame is filtered with one consistent threshold set.
- Sits between the board buttons/switches and the detector's iFreezeRam, iCrLow/High and iCbLow/High inputs.

Parameters:
- STEP, 4: increment/decrement applied per step pulse (1..255).
- CR_LOW_INIT, 8'd150: reset value of Cr low threshold.
- CR_HIGH_INIT, 8'd255: reset value of Cr high threshold.
- CB_LOW_INIT, 8'd0: reset value of Cb low threshold.
- CB_HIGH_INIT, 8'd120: reset value of Cb high threshold.

Ports:
- iVgaClk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- iVgaVRequest  in  1  high during vertical active area; synchronous to iVgaClk.
- iCaptureReq  in  1  one-cycle pulse: capture one frame, then freeze.
- iLiveReq  in  1  one-cycle pulse: return to continuous live writing.
- iStepUp  in  1  one-cycle pulse: increment the selected threshold.
- iStepDown  in  1  one-cycle pulse: decrement the selected threshold.
- iFieldSel  in  2  selects the threshold: 0 CrLow, 1 CrHigh, 2 CbLow, 3 CbHigh.
- oFreezeRam  out  1  to detector iFreezeRam.
- oCrLow, oCrHigh, oCbLow, oCbHigh  out  8 each  active thresholds to the detector.
- oState  out  2  current FSM state: LIVE=0, ARM=1, CAPTURE=2, FROZEN=3.
- oFrameCount  out  8  frame-start counter; wraps 255->0.

Behaviour:
- Reset (asynchronous): state LIVE, oFreezeRam=0, oFrameCount=0, vreq_d=0. Shadow and active thresholds both load their *_INIT values.
- Frame-start detect: vreq_d registers iVgaVRequest. fs = iVgaVRequest & ~vreq_d. fe = ~iVgaVRequest & vreq_d.
- oFrameCount increments on every fs cycle.
- FSM, one transition per cycle, registered:
  - LIVE: freeze=0. On iCaptureReq go to ARM.
  - ARM: freeze=1 (no partial-frame writes). On fs go to CAPTURE.
  - CAPTURE: freeze=0. On fe go to FROZEN. iCaptureReq and iLiveReq are ignored.
  - FROZEN: freeze=1. On iCaptureReq go to ARM. On iLiveReq go to LIVE.
  - iCaptureReq and iLiveReq in the same cycle: capture wins.
  - iLiveReq in ARM returns to LIVE.
- oFreezeRam is decoded from the registered state, so it follows the state with zero extra latency. If ARM sees fs in cycle N, oFreezeRam=0 from cycle N+1. The first pixel of the frame is therefore missed only if fs coincides with pixel 0. Accepted: fs is generated at the vertical-request edge, before the first active line.
- Threshold editing acts on shadow registers only:
  - iStepUp adds STEP to the selected shadow register, saturating at 255. iStepDown subtracts STEP, saturating at 0.
  - iStepUp and iStepDown in the same cycle: no change.
  - Ordering clamp on each pair: a low increment may not exceed the shadow high (result is min(low+STEP, high)). A high decrement may not go below the shadow low (result is max(high-STEP, low)).
  - Arithmetic is 9-bit internally to detect overflow/underflow.
- Active outputs copy all four shadow registers on the fs cycle, visible from cycle N+1. A step in the same cycle as fs is not included in that copy; it applies at the next fs.
- Reset asserted mid-CAPTURE: immediate LIVE, freeze=0, and thresholds revert to *_INIT.

Decomposition:
- Shared package ball_detect_pkg holds:
  - the state encoding constants (LIVE, ARM, CAPTURE, FROZEN);
  - the field-select constants (SEL_CR_LOW..SEL_CB_HIGH);
  - default threshold constants.
- One sub-module, threshold_bank: four shadow registers, saturating/clamped step logic, frame-start transfer to active outputs.
- The FSM and frame counter live in the top level.

Test Plan:
- Reset, then run 3 frames with no requests -> oState=0, oFreezeRam=0 throughout, oFrameCount=3, outputs = 150/255/0/120.
- iCaptureReq mid-frame (line 200) -> oFreezeRam=1 until next fs. It is 0 for exactly one full iVgaVRequest-high period, then FROZEN with freeze=1. iLiveReq -> LIVE next cycle.
- iFieldSel=0, iStepUp x30 -> shadow CrLow clamps at 255 (=CrHigh). oCrLow stays 150 until next fs, then 255 one cycle after fs.
- iFieldSel=2, iStepDown x3 from 0 -> stays 0. iFieldSel=3, iStepDown x40 -> CbHigh floors at CbLow=0. iStepUp and iStepDown together -> no change.
- iCaptureReq and iLiveReq same cycle in FROZEN -> ARM. iStepUp on the exact fs cycle -> the change appears only after the following fs.
- Assert reset during CAPTURE with modified thresholds -> oState=0, oFreezeRam=0, thresholds = *_INIT immediately (asynchronously, no clock edge).

Source files
------------

// File: rtl/ball_detect_pkg.sv
// Shared types and constants for the red-ball detector frame/threshold controller.
// Holds the FSM state encoding, field-select codes, threshold defaults and saturating helpers.
package ball_detect_pkg;

    localparam int unsigned TH_W     = 8;
    localparam int unsigned TH_EXT_W = TH_W + 1;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned ST_W     = 2;

    typedef enum logic [ST_W-1:0] {
        LIVE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        FROZEN  = 2'd3
    } state_e;

    localparam logic [SEL_W-1:0] SEL_CR_LOW  = 2'd0;
    localparam logic [SEL_W-1:0] SEL_CR_HIGH = 2'd1;
    localparam logic [SEL_W-1:0] SEL_CB_LOW  = 2'd2;
    localparam logic [SEL_W-1:0] SEL_CB_HIGH = 2'd3;

    localparam logic [TH_W-1:0] DEF_CR_LOW  = 8'd150;
    localparam logic [TH_W-1:0] DEF_CR_HIGH = 8'd255;
    localparam logic [TH_W-1:0] DEF_CB_LOW  = 8'd0;
    localparam logic [TH_W-1:0] DEF_CB_HIGH = 8'd120;

    typedef struct packed {
        logic [TH_W-1:0] cr_low;
        logic [TH_W-1:0] cr_high;
        logic [TH_W-1:0] cb_low;
        logic [TH_W-1:0] cb_high;
    } thresh_t;

    // The extra bit of the 9-bit result flags overflow/underflow.
    function automatic logic [TH_W-1:0] sat_add(input logic [TH_W-1:0] a,
                                                input logic [TH_W-1:0] b);
        logic [TH_EXT_W-1:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[TH_W] ? {TH_W{1'b1}} : s[TH_W-1:0];
    endfunction

    function automatic logic [TH_W-1:0] sat_sub(input logic [TH_W-1:0] a,
                                                input logic [TH_W-1:0] b);
        logic [TH_EXT_W-1:0] s;
        s = {1'b0, a} - {1'b0, b};
        return s[TH_W] ? {TH_W{1'b0}} : s[TH_W-1:0];
    endfunction

    function automatic logic [TH_W-1:0] min_th(input logic [TH_W-1:0] a,
                                               input logic [TH_W-1:0] b);
        return (a > b) ? b : a;
    endfunction

    function automatic logic [TH_W-1:0] max_th(input logic [TH_W-1:0] a,
                                               input logic [TH_W-1:0] b);
        return (a < b) ? b : a;
    endfunction

endpackage

// File: rtl/ball_detect_ctrl_if.sv
// Board-side control bus of the detector controller: VGA timing, buttons, switches
// and the freeze/threshold outputs that feed the detector datapath.
interface ball_detect_ctrl_if;
    import ball_detect_pkg::*;

    logic                 iVgaVRequest;
    logic                 iCaptureReq;
    logic                 iLiveReq;
    logic                 iStepUp;
    logic                 iStepDown;
    logic [SEL_W-1:0]     iFieldSel;
    logic                 oFreezeRam;
    logic [TH_W-1:0]      oCrLow;
    logic [TH_W-1:0]      oCrHigh;
    logic [TH_W-1:0]      oCbLow;
    logic [TH_W-1:0]      oCbHigh;
    logic [ST_W-1:0]      oState;
    logic [CNT_W-1:0]     oFrameCount;

    modport master (
        output iVgaVRequest, iCaptureReq, iLiveReq, iStepUp, iStepDown, iFieldSel,
        input  oFreezeRam, oCrLow, oCrHigh, oCbLow, oCbHigh, oState, oFrameCount
    );

    modport slave (
        input  iVgaVRequest, iCaptureReq, iLiveReq, iStepUp, iStepDown, iFieldSel,
        output oFreezeRam, oCrLow, oCrHigh, oCbLow, oCbHigh, oState, oFrameCount
    );

endinterface

// File: rtl/ball_detect_ctrl_threshold_bank.sv
// Four shadow threshold registers edited by step pulses, with saturation and
// low<=high ordering clamps; the active set is copied from the shadows at frame start.
module threshold_bank
    import ball_detect_pkg::*;
#(
    parameter int unsigned     STEP         = 4,
    parameter logic [TH_W-1:0] CR_LOW_INIT  = DEF_CR_LOW,
    parameter logic [TH_W-1:0] CR_HIGH_INIT = DEF_CR_HIGH,
    parameter logic [TH_W-1:0] CB_LOW_INIT  = DEF_CB_LOW,
    parameter logic [TH_W-1:0] CB_HIGH_INIT = DEF_CB_HIGH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_fs,
    input  logic             i_step_up,
    input  logic             i_step_down,
    input  logic [SEL_W-1:0] i_field_sel,
    output thresh_t          o_active
);

    localparam logic [TH_W-1:0] STEP_V = TH_W'(STEP);
    localparam thresh_t         INIT_V = '{cr_low:  CR_LOW_INIT,
                                           cr_high: CR_HIGH_INIT,
                                           cb_low:  CB_LOW_INIT,
                                           cb_high: CB_HIGH_INIT};

    thresh_t r_shadow;
    thresh_t r_active;
    thresh_t w_shadow_nxt;
    logic    w_up;
    logic    w_dn;

    // Simultaneous up and down cancel out.
    assign w_up = i_step_up & ~i_step_down;
    assign w_dn = i_step_down & ~i_step_up;

    // Step logic: lows cannot climb above their high, highs cannot drop below their low.
    always_comb begin
        w_shadow_nxt = r_shadow;
        case (i_field_sel)
            SEL_CR_LOW: begin
                if (w_up) w_shadow_nxt.cr_low = min_th(sat_add(r_shadow.cr_low, STEP_V), r_shadow.cr_high);
                if (w_dn) w_shadow_nxt.cr_low = sat_sub(r_shadow.cr_low, STEP_V);
            end
            SEL_CR_HIGH: begin
                if (w_up) w_shadow_nxt.cr_high = sat_add(r_shadow.cr_high, STEP_V);
                if (w_dn) w_shadow_nxt.cr_high = max_th(sat_sub(r_shadow.cr_high, STEP_V), r_shadow.cr_low);
            end
            SEL_CB_LOW: begin
                if (w_up) w_shadow_nxt.cb_low = min_th(sat_add(r_shadow.cb_low, STEP_V), r_shadow.cb_high);
                if (w_dn) w_shadow_nxt.cb_low = sat_sub(r_shadow.cb_low, STEP_V);
            end
            default: begin
                if (w_up) w_shadow_nxt.cb_high = sat_add(r_shadow.cb_high, STEP_V);
                if (w_dn) w_shadow_nxt.cb_high = max_th(sat_sub(r_shadow.cb_high, STEP_V), r_shadow.cb_low);
            end
        endcase
    end

    // Active set takes the pre-step shadow value on fs, so a same-cycle step waits a frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shadow <= INIT_V;
            r_active <= INIT_V;
        end else begin
            r_shadow <= w_shadow_nxt;
            if (i_fs) r_active <= r_shadow;
        end
    end

    assign o_active = r_active;

endmodule

// File: rtl/ball_detect_ctrl.sv
// Frame sequencing and threshold configuration for the red-ball detector:
// single-shot capture/freeze FSM, frame counter and frame-aligned threshold bank.
module ball_detect_ctrl
    import ball_detect_pkg::*;
#(
    parameter int unsigned     STEP         = 4,
    parameter logic [TH_W-1:0] CR_LOW_INIT  = DEF_CR_LOW,
    parameter logic [TH_W-1:0] CR_HIGH_INIT = DEF_CR_HIGH,
    parameter logic [TH_W-1:0] CB_LOW_INIT  = DEF_CB_LOW,
    parameter logic [TH_W-1:0] CB_HIGH_INIT = DEF_CB_HIGH
) (
    input  logic              iVgaClk,
    input  logic              reset,
    ball_detect_ctrl_if.slave bus
);

    logic             r_vreq_d;
    logic             w_fs;
    logic             w_fe;
    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_freeze;
    logic             w_freeze_nxt;
    logic [CNT_W-1:0] r_frame_cnt;
    thresh_t          w_active;

    assign w_fs = bus.iVgaVRequest & ~r_vreq_d;
    assign w_fe = ~bus.iVgaVRequest & r_vreq_d;

    // Vertical-request edge tracking and frame-start counter.
    always_ff @(posedge iVgaClk or posedge reset) begin
        if (reset) begin
            r_vreq_d    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_vreq_d <= bus.iVgaVRequest;
            if (w_fs) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge iVgaClk or posedge reset) begin
        if (reset) begin
            r_state  <= LIVE;
            r_freeze <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_freeze <= w_freeze_nxt;
        end
    end

    // Freeze is derived from the next state so it switches on the same edge as the state.
    always_comb begin
        w_state_nxt  = r_state;
        w_freeze_nxt = 1'b0;
        case (r_state)
            LIVE: begin
                if (bus.iCaptureReq) w_state_nxt = ARM;
            end
            ARM: begin
                if (w_fs)              w_state_nxt = CAPTURE;
                else if (bus.iLiveReq) w_state_nxt = LIVE;
            end
            CAPTURE: begin
                if (w_fe) w_state_nxt = FROZEN;
            end
            FROZEN: begin
                if (bus.iCaptureReq)   w_state_nxt = ARM;
                else if (bus.iLiveReq) w_state_nxt = LIVE;
            end
            default: w_state_nxt = LIVE;
        endcase
        w_freeze_nxt = (w_state_nxt == ARM) || (w_state_nxt == FROZEN);
    end

    threshold_bank #(
        .STEP         (STEP),
        .CR_LOW_INIT  (CR_LOW_INIT),
        .CR_HIGH_INIT (CR_HIGH_INIT),
        .CB_LOW_INIT  (CB_LOW_INIT),
        .CB_HIGH_INIT (CB_HIGH_INIT)
    ) u_threshold_bank (
        .i_clk       (iVgaClk),
        .i_rst       (reset),
        .i_fs        (w_fs),
        .i_step_up   (bus.iStepUp),
        .i_step_down (bus.iStepDown),
        .i_field_sel (bus.iFieldSel),
        .o_active    (w_active)
    );

    assign bus.oFreezeRam  = r_freeze;
    assign bus.oState      = r_state;
    assign bus.oFrameCount = r_frame_cnt;
    assign bus.oCrLow      = w_active.cr_low;
    assign bus.oCrHigh     = w_active.cr_high;
    assign bus.oCbLow      = w_active.cb_low;
    assign bus.oCbHigh     = w_active.cb_high;

endmodule

// File: tb/tb_ball_detect_ctrl.sv
// Directed scoreboard bench for ball_detect_ctrl: capture/freeze sequencing,
// frame counting, clamped threshold stepping and frame-aligned threshold transfer.
module tb_ball_detect_ctrl;
    import ball_detect_pkg::*;

    localparam int ACT = 20;
    localparam int BLK = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ball_detect_ctrl_if bus_if();

    ball_detect_ctrl #(
        .STEP         (4),
        .CR_LOW_INIT  (8'd150),
        .CR_HIGH_INIT (8'd255),
        .CB_LOW_INIT  (8'd0),
        .CB_HIGH_INIT (8'd120)
    ) dut (
        .iVgaClk (clk),
        .reset   (rst),
        .bus     (bus_if)
    );

    int          errors = 0;
    int          checks = 0;
    int          exp_fc = 0;
    int          zero_cnt;
    logic [31:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: observed %0d, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
            end
        end
    endtask

    task automatic exp_all(input int st, input int fr, input int fc,
                           input int crl, input int crh, input int cbl, input int cbh);
        push(32'(st)); push(32'(fr)); push(32'(fc));
        push(32'(crl)); push(32'(crh)); push(32'(cbl)); push(32'(cbh));
    endtask

    task automatic chk_all(input string tag);
        check({tag, ".state"},  32'(bus_if.oState));
        check({tag, ".freeze"}, 32'(bus_if.oFreezeRam));
        check({tag, ".fcount"}, 32'(bus_if.oFrameCount));
        check({tag, ".crlow"},  32'(bus_if.oCrLow));
        check({tag, ".crhigh"}, 32'(bus_if.oCrHigh));
        check({tag, ".cblow"},  32'(bus_if.oCbLow));
        check({tag, ".cbhigh"}, 32'(bus_if.oCbHigh));
    endtask

    task automatic set_vreq(input logic v);
        if (v && !bus_if.iVgaVRequest) exp_fc = (exp_fc + 1) % 256;
        bus_if.iVgaVRequest = v;
    endtask

    task automatic step(input logic up, input logic dn, input logic [1:0] sel);
        bus_if.iFieldSel = sel;
        bus_if.iStepUp   = up;
        bus_if.iStepDown = dn;
        tick();
        bus_if.iStepUp   = 1'b0;
        bus_if.iStepDown = 1'b0;
    endtask

    task automatic pulse(input logic cap, input logic live);
        bus_if.iCaptureReq = cap;
        bus_if.iLiveReq    = live;
        tick();
        bus_if.iCaptureReq = 1'b0;
        bus_if.iLiveReq    = 1'b0;
    endtask

    initial begin
        bus_if.iVgaVRequest = 1'b0;
        bus_if.iCaptureReq  = 1'b0;
        bus_if.iLiveReq     = 1'b0;
        bus_if.iStepUp      = 1'b0;
        bus_if.iStepDown    = 1'b0;
        bus_if.iFieldSel    = 2'd0;
        rst = 1'b1;
        #2;
        exp_all(0, 0, 0, 150, 255, 0, 120);
        chk_all("reset");
        tick(); tick();
        rst = 1'b0;
        tick();

        // Three idle frames in LIVE.
        for (int f = 0; f < 3; f++) begin
            set_vreq(1'b1);
            for (int k = 0; k < ACT; k++) begin
                tick();
                if (k == ACT / 2) begin
                    push(0); push(0);
                    check("idle.state", 32'(bus_if.oState));
                    check("idle.freeze", 32'(bus_if.oFreezeRam));
                end
            end
            set_vreq(1'b0);
            repeat (BLK) tick();
        end
        exp_all(0, 0, exp_fc, 150, 255, 0, 120);
        chk_all("idle3");

        // Capture requested mid-frame: frozen until the next frame start.
        set_vreq(1'b1);
        repeat (10) tick();
        pulse(1'b1, 1'b0);
        push(1); push(1);
        check("arm.state", 32'(bus_if.oState));
        check("arm.freeze", 32'(bus_if.oFreezeRam));
        repeat (ACT - 11) tick();
        set_vreq(1'b0);
        repeat (BLK) tick();
        exp_all(1, 1, exp_fc, 150, 255, 0, 120);
        chk_all("arm_blank");

        set_vreq(1'b1);
        tick();
        exp_all(2, 0, exp_fc, 150, 255, 0, 120);
        chk_all("capture");
        zero_cnt = (bus_if.oFreezeRam === 1'b0) ? 1 : 0;
        for (int k = 2; k <= ACT; k++) begin
            bus_if.iCaptureReq = (k == 8);
            bus_if.iLiveReq    = (k == 12);
            tick();
            if (bus_if.oFreezeRam === 1'b0) zero_cnt++;
        end
        bus_if.iCaptureReq = 1'b0;
        bus_if.iLiveReq    = 1'b0;
        push(2);
        check("capture_hold.state", 32'(bus_if.oState));
        set_vreq(1'b0);
        tick();
        push(3); push(1); push(32'(ACT));
        check("frozen.state", 32'(bus_if.oState));
        check("frozen.freeze", 32'(bus_if.oFreezeRam));
        check("capture_len", 32'(zero_cnt));
        repeat (BLK - 1) tick();
        pulse(1'b0, 1'b1);
        push(0); push(0);
        check("live.state", 32'(bus_if.oState));
        check("live.freeze", 32'(bus_if.oFreezeRam));

        // Threshold stepping with saturation and ordering clamps.
        repeat (30) step(1'b1, 1'b0, SEL_CR_LOW);
        repeat (2)  step(1'b0, 1'b1, SEL_CR_HIGH);
        step(1'b1, 1'b1, SEL_CR_LOW);
        repeat (3)  step(1'b0, 1'b1, SEL_CB_LOW);
        repeat (40) step(1'b0, 1'b1, SEL_CB_HIGH);
        step(1'b1, 1'b1, SEL_CB_HIGH);
        exp_all(0, 0, exp_fc, 150, 255, 0, 120);
        chk_all("shadow_only");
        set_vreq(1'b1);
        push(150);
        check("fs_cycle.crlow", 32'(bus_if.oCrLow));
        tick();
        exp_all(0, 0, exp_fc, 255, 255, 0, 0);
        chk_all("after_fs");
        repeat (ACT - 1) tick();
        set_vreq(1'b0);
        repeat (BLK) tick();

        // Capture+live together in FROZEN, then a step on the fs cycle.
        pulse(1'b1, 1'b0);
        set_vreq(1'b1);
        tick();
        repeat (ACT - 1) tick();
        set_vreq(1'b0);
        tick();
        push(3);
        check("frozen2.state", 32'(bus_if.oState));
        repeat (BLK - 1) tick();
        pulse(1'b1, 1'b1);
        push(1); push(1);
        check("cap_wins.state", 32'(bus_if.oState));
        check("cap_wins.freeze", 32'(bus_if.oFreezeRam));
        set_vreq(1'b1);
        step(1'b1, 1'b0, SEL_CB_HIGH);
        exp_all(2, 0, exp_fc, 255, 255, 0, 0);
        chk_all("fs_step");
        repeat (ACT - 1) tick();
        set_vreq(1'b0);
        repeat (BLK) tick();
        set_vreq(1'b1);
        tick();
        exp_all(3, 1, exp_fc, 255, 255, 0, 4);
        chk_all("fs_step_next");
        repeat (ACT - 1) tick();
        set_vreq(1'b0);
        repeat (BLK) tick();

        // Asynchronous reset in the middle of a capture.
        pulse(1'b1, 1'b0);
        set_vreq(1'b1);
        tick();
        push(2);
        check("capture3.state", 32'(bus_if.oState));
        repeat (5) tick();
        #1;
        rst = 1'b1;
        exp_fc = 0;
        #1;
        exp_all(0, 0, exp_fc, 150, 255, 0, 120);
        chk_all("rst_capture");
        tick();
        rst = 1'b0;
        set_vreq(1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
